// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multicycle execute-stage ALU:
//   - opcode encodings (ALU_ADD .. ALU_DIVU)
//   - FSM state encoding (IDLE / EXEC / ITER / DONE)
//   - bit positions of the packed flag vector
//   - helper telling which opcodes run on the iterative unit
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_MUL  = 3'b110;
    localparam logic [2:0] ALU_DIVU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } alu_state_t;

    localparam int FLAG_N    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_V    = 3;
    localparam int FLAG_DZ   = 4;
    localparam int NUM_FLAGS = 5;

    // Multiply and divide are the only opcodes that need the iterative unit.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// ----------------------------------------------------------------------------
// alu_iter_unit
// Iterative unsigned multiply (shift-add, low WIDTH bits) and unsigned divide
// (restoring, quotient). One bit is processed per clock, WIDTH steps per op.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      one-cycle pulse: load a_i/b_i/is_div_i and begin
//   is_div_i     1 = divu, 0 = mul
//   a_i, b_i     operands (multiplicand/multiplier or dividend/divisor)
//   done_o       one-cycle pulse, high the cycle after the last step
//   result_o     product low half or quotient; stable after done_o
// ----------------------------------------------------------------------------
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    // acc: running product (mul) or partial remainder (div)
    // opnd: shifted multiplicand (mul) or dividend/quotient shift register (div)
    // opb: shifted multiplier (mul) or divisor (div)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             is_div_q, is_div_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            is_div_q <= is_div_d;
        end
    end

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        is_div_d = is_div_q;

        // Restoring-division trial subtraction; bit WIDTH set means the
        // shifted remainder was smaller than the divisor. A zero divisor
        // never borrows, so the quotient naturally fills with ones.
        rem_shift = {acc_q, opnd_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, opb_q};

        if (start_i) begin
            acc_d    = '0;
            opnd_d   = a_i;
            opb_d    = b_i;
            cnt_d    = '0;
            busy_d   = 1'b1;
            is_div_d = is_div_i;
        end else if (busy_q) begin
            if (is_div_q) begin
                if (diff[WIDTH]) begin
                    acc_d  = rem_shift[WIDTH-1:0];
                    opnd_d = {opnd_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d  = diff[WIDTH-1:0];
                    opnd_d = {opnd_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                if (opb_q[0]) begin
                    acc_d = acc_q + opnd_q;
                end
                opnd_d = opnd_q << 1;
                opb_d  = opb_q >> 1;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    assign done_o   = done_q;
    assign result_o = is_div_q ? opnd_q : acc_q;

endmodule

// File: rtl/multicycle_alu.sv
// ----------------------------------------------------------------------------
// multicycle_alu
// Registered execute-stage ALU with valid/ready handshake. Single-cycle ops
// (add/sub/and/or/slt/sll) pass through EXEC; mul/divu run on alu_iter_unit.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake; in_ready only in IDLE
//   a, b, alu_control      operands and opcode, captured on accept
//   out_valid / out_ready  result handshake; result held while stalled
//   result                 registered result
//   negative, carry, zero, overflow, div_by_zero   registered flags
// ----------------------------------------------------------------------------
module multicycle_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    alu_state_t             state_q, state_d;
    logic [WIDTH-1:0]       a_q, b_q;
    logic [2:0]             op_q;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;
    logic                   out_valid_q, out_valid_d;

    logic                   accept;
    logic                   iter_start;
    logic                   iter_done;
    logic [WIDTH-1:0]       iter_result;

    logic [WIDTH-1:0]       op_b;
    logic [WIDTH:0]         sum;
    logic [WIDTH-1:0]       alu_res;
    logic [NUM_FLAGS-1:0]   alu_flags;
    logic [NUM_FLAGS-1:0]   iter_flags;

    assign accept     = in_valid && (state_q == IDLE);
    assign iter_start = accept && is_iter_op(alu_control);

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (iter_start),
        .is_div_i (alu_control == ALU_DIVU),
        .a_i      (a),
        .b_i      (b),
        .done_o   (iter_done),
        .result_o (iter_result)
    );

    // Operand/opcode capture: later input changes must not disturb an op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= ALU_ADD;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= alu_control;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Single-cycle datapath. Subtraction is a + ~b + 1 so carry is NOT-borrow.
    always_comb begin
        op_b      = (op_q == ALU_SUB) ? ~b_q : b_q;
        sum       = {1'b0, a_q} + {1'b0, op_b} + {{WIDTH{1'b0}}, (op_q == ALU_SUB)};
        alu_res   = '0;
        alu_flags = '0;
        case (op_q)
            ALU_ADD, ALU_SUB: begin
                alu_res           = sum[WIDTH-1:0];
                alu_flags[FLAG_C] = sum[WIDTH];
                alu_flags[FLAG_V] = (a_q[WIDTH-1] == op_b[WIDTH-1]) &&
                                    (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_AND: alu_res = a_q & b_q;
            ALU_OR:  alu_res = a_q | b_q;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            ALU_SLL: alu_res = a_q << b_q[SHW-1:0];
            default: alu_res = '0;
        endcase
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
    end

    always_comb begin
        iter_flags          = '0;
        iter_flags[FLAG_N]  = iter_result[WIDTH-1];
        iter_flags[FLAG_Z]  = (iter_result == '0);
        iter_flags[FLAG_DZ] = (op_q == ALU_DIVU) && (b_q == '0);
    end

    // Control FSM. Results are written on the way into DONE; out_valid rises
    // one cycle later and drops only on a completed output handshake.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = is_iter_op(alu_control) ? ITER : EXEC;
                end
            end
            EXEC: begin
                state_d  = DONE;
                result_d = alu_res;
                flags_d  = alu_flags;
            end
            ITER: begin
                if (iter_done) begin
                    state_d  = DONE;
                    result_d = iter_result;
                    flags_d  = iter_flags;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign negative    = flags_q[FLAG_N];
    assign carry       = flags_q[FLAG_C];
    assign zero        = flags_q[FLAG_Z];
    assign overflow    = flags_q[FLAG_V];
    assign div_by_zero = flags_q[FLAG_DZ];

endmodule
